// File: rtl/mem_access_initiator.sv
// Load/store initiator for the ROM/RAM memory system: validates each request against the
// ROM and RAM windows, issues legal accesses for one cycle and returns data or an error.
module mem_access_initiator #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] ROM_BASE     = 32'h0040_0000,
  parameter logic [31:0] RAM_BASE     = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_error_o,
  output logic [31:0]           Instruction_Range_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [15:0]           txn_count_o
);

  localparam int unsigned ExtW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_error_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [31:0]           range_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [15:0]           txn_q;
  logic                  load_ok_q;
  logic                  err_q;

  // One extra bit on the bounds so a window ending at the top of the space cannot wrap.
  logic [DATA_WIDTH:0] addr_ext, rom_lo, rom_hi, ram_lo, ram_hi;
  logic                rom_hit_d, ram_hit_d, err_d;

  always_comb begin
    addr_ext  = {1'b0, req_addr_i};
    rom_lo    = ExtW'(ROM_BASE);
    rom_hi    = rom_lo + ExtW'(4 * MEMORY_DEPTH);
    ram_lo    = ExtW'(RAM_BASE);
    ram_hi    = ram_lo + ExtW'(4 * MEMORY_DEPTH);
    rom_hit_d = (addr_ext >= rom_lo) && (addr_ext < rom_hi);
    ram_hit_d = (addr_ext >= ram_lo) && (addr_ext < ram_hi);
    err_d     = (req_addr_i[1:0] != 2'b00) || !(rom_hit_d || ram_hit_d) ||
                (rom_hit_d && req_write_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      range_q      <= RAM_BASE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      txn_q        <= '0;
      load_ok_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_q) begin
            state_q     <= StIssue;
            req_ready_q <= 1'b0;
            err_q       <= err_d;
            load_ok_q   <= !err_d && !req_write_i;
            if (!err_d) begin
              range_q <= rom_hit_d ? ROM_BASE : RAM_BASE;
              addr_q  <= req_addr_i;
              if (req_write_i) begin
                we_q    <= 1'b1;
                wdata_q <= req_wdata_i;
              end
            end
          end
        end
        StIssue: begin
          state_q      <= StResp;
          we_q         <= 1'b0;
          wdata_q      <= '0;
          resp_valid_q <= 1'b1;
          resp_error_q <= err_q;
          resp_rdata_q <= load_ok_q ? Instruction_i : '0;
        end
        StResp: begin
          if (resp_ready_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            txn_q        <= txn_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o         = req_ready_q;
  assign resp_valid_o        = resp_valid_q;
  assign resp_error_o        = resp_error_q;
  assign resp_rdata_o        = resp_rdata_q;
  assign Instruction_Range_o = range_q;
  assign Address_o           = addr_q;
  // Gated by reset so a store aborted mid-ISSUE never reaches the RAM commit edge.
  assign Write_Enable_o      = we_q & ~reset;
  assign Write_Data_o        = wdata_q;
  assign txn_count_o         = txn_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator with a small ROM/RAM model behind the memory ports.
module tb_mem_access_initiator;

  localparam logic [31:0] RomBase = 32'h0040_0000;
  localparam logic [31:0] RamBase = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_error_o;
  logic [31:0] Instruction_Range_o;
  logic [31:0] Address_o;
  logic        Write_Enable_o;
  logic [31:0] Write_Data_o;
  logic [31:0] Instruction_i;
  logic [15:0] txn_count_o;

  always #5 clk = ~clk;

  mem_access_initiator dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_write_i        (req_write_i),
    .req_addr_i         (req_addr_i),
    .req_wdata_i        (req_wdata_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_rdata_o       (resp_rdata_o),
    .resp_error_o       (resp_error_o),
    .Instruction_Range_o(Instruction_Range_o),
    .Address_o          (Address_o),
    .Write_Enable_o     (Write_Enable_o),
    .Write_Data_o       (Write_Data_o),
    .Instruction_i      (Instruction_i),
    .txn_count_o        (txn_count_o)
  );

  // Memory system model: virtual-to-physical decode and output mux.
  logic [31:0] rom [64];
  logic [31:0] ram [64];
  logic [31:0] offset;
  logic [5:0]  idx;
  assign offset        = Address_o - Instruction_Range_o;
  assign idx           = offset[7:2];
  assign Instruction_i = (Instruction_Range_o == RomBase) ? rom[idx] : ram[idx];

  always @(posedge clk) if (Write_Enable_o) ram[idx] <= Write_Data_o;

  // Write strobe monitor.
  int          we_cnt = 0;
  int          we_long = 0;
  logic        we_prev = 1'b0;
  logic [31:0] we_range = '0;
  always @(posedge clk) begin
    if (Write_Enable_o) begin
      we_cnt   <= we_cnt + 1;
      we_range <= Instruction_Range_o;
      if (we_prev) we_long <= we_long + 1;
    end
    we_prev <= Write_Enable_o;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic do_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(negedge clk);
    req_valid_i = 1'b0;
    check({tag, " issue_valid"}, 32'(resp_valid_o), 32'd0);
    check({tag, " issue_ready"}, 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check({tag, " latency_valid"}, 32'(resp_valid_o), 32'd1);
    rdata = resp_rdata_o;
    err   = resp_error_o;
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    exp_cnt++;
    check({tag, " txn_count"}, 32'(txn_count_o), 32'(exp_cnt));
    check({tag, " back_idle"}, 32'(req_ready_o), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] held;
  int          we_before;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h2008_0005;

    // Reset, then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst ready", 32'(req_ready_o), 32'd1);
    check("rst valid", 32'(resp_valid_o), 32'd0);
    check("rst we", 32'(Write_Enable_o), 32'd0);
    check("rst count", 32'(txn_count_o), 32'd0);
    check("rst range", Instruction_Range_o, RamBase);
    check("rst addr", Address_o, 32'd0);

    // Store then load RAM
    do_txn("st_ram", 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, rd, er);
    check("st_ram err", 32'(er), 32'd0);
    check("st_ram we_cnt", 32'(we_cnt), 32'd1);
    check("st_ram we_range", we_range, RamBase);
    do_txn("ld_ram", 1'b0, 32'h1001_0008, 32'h0, rd, er);
    check("ld_ram data", rd, 32'hDEAD_BEEF);
    check("ld_ram err", 32'(er), 32'd0);
    check("ld_ram count2", 32'(txn_count_o), 32'd2);

    // Last RAM word is legal
    do_txn("st_last", 1'b1, 32'h1001_00FC, 32'h1234_5678, rd, er);
    check("st_last err", 32'(er), 32'd0);
    do_txn("ld_last", 1'b0, 32'h1001_00FC, 32'h0, rd, er);
    check("ld_last data", rd, 32'h1234_5678);

    // ROM load
    do_txn("ld_rom", 1'b0, 32'h0040_0000, 32'h0, rd, er);
    check("ld_rom range", Instruction_Range_o, RomBase);
    check("ld_rom data", rd, 32'h2008_0005);
    check("ld_rom err", 32'(er), 32'd0);

    // Errors
    we_before = we_cnt;
    do_txn("st_rom", 1'b1, 32'h0040_0004, 32'hAAAA_5555, rd, er);
    check("st_rom err", 32'(er), 32'd1);
    check("st_rom no_we", 32'(we_cnt), 32'(we_before));
    do_txn("ld_mis", 1'b0, 32'h1001_0002, 32'h0, rd, er);
    check("ld_mis err", 32'(er), 32'd1);
    check("ld_mis data", rd, 32'd0);
    do_txn("ld_past", 1'b0, 32'h1001_0100, 32'h0, rd, er);
    check("ld_past err", 32'(er), 32'd1);
    do_txn("ld_top", 1'b0, 32'hFFFF_FFFC, 32'h0, rd, er);
    check("ld_top err", 32'(er), 32'd1);
    check("ld_top data", rd, 32'd0);
    do_txn("ld_below", 1'b0, 32'h003F_FFFC, 32'h0, rd, er);
    check("ld_below err", 32'(er), 32'd1);

    // Backpressure: hold resp_ready low for 5 cycles with a competing request present
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h1001_0008;
    @(negedge clk);
    req_addr_i  = 32'h1001_00FC;
    @(negedge clk);
    held = resp_rdata_o;
    check("bp data0", held, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 32'(resp_valid_o), 32'd1);
      check("bp ready", 32'(req_ready_o), 32'd0);
      check("bp data", resp_rdata_o, held);
      check("bp err", 32'(resp_error_o), 32'd0);
      @(negedge clk);
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    exp_cnt++;
    check("bp count", 32'(txn_count_o), 32'(exp_cnt));
    check("bp idle_ready", 32'(req_ready_o), 32'd1);
    check("bp idle_valid", 32'(resp_valid_o), 32'd0);
    repeat (2) @(negedge clk);
    check("bp no_new_txn", 32'(resp_valid_o), 32'd0);

    // Reset during ISSUE of a store
    we_before = we_cnt;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h1001_0008;
    req_wdata_i = 32'h1111_1111;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rst_iss we_high", 32'(Write_Enable_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_iss no_commit", 32'(we_cnt), 32'(we_before));
    check("rst_iss ready", 32'(req_ready_o), 32'd1);
    check("rst_iss valid", 32'(resp_valid_o), 32'd0);
    check("rst_iss count", 32'(txn_count_o), 32'd0);
    exp_cnt = 0;
    do_txn("ld_after_rst", 1'b0, 32'h1001_0008, 32'h0, rd, er);
    check("ld_after_rst data", rd, 32'hDEAD_BEEF);

    check("we_single_cycle", 32'(we_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
